// File: rtl/keccak_masked_pkg.sv
// Shared sizing helpers for the masked Keccak chi/iota datapath and its randomness stage.
package keccak_masked_pkg;

    // Fresh-mask bits needed by one S-box evaluation: one 5-bit slot per share pair.
    function automatic int z_width(input int shares);
        return ((shares * shares - shares) / 32'sd2) * 32'sd5;
    endfunction

    function automatic int z_need(input int shares, input int less_rand);
        return (less_rand != 32'sd0) ? (z_width(shares) - 32'sd5) : z_width(shares);
    endfunction

    function automatic int words_per_z(input int need, input int rand_w);
        return (need + rand_w - 32'sd1) / rand_w;
    endfunction

endpackage

// File: rtl/keccak_rand_fifo.sv
// Generic synchronous FIFO for Z vectors; KECCAK_RAND_ZEROIZE_EN clears slots once consumed.
module keccak_rand_fifo #(
    parameter int WIDTH = 50,
    parameter int DEPTH = 4,
    localparam int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             ClkxCI,
    input  logic             RstxRBI,
    input  logic             PushxSI,
    input  logic [WIDTH-1:0] DataxDI,
    input  logic             PopxSI,
    output logic [WIDTH-1:0] DataxDO,
    output logic             FullxSO,
    output logic             EmptyxSO,
    output logic [LVL_W-1:0] LevelxDO
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [LVL_W-1:0] level_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign FullxSO   = (level_r == LVL_W'(DEPTH));
    assign EmptyxSO  = (level_r == LVL_W'(0));
    assign LevelxDO  = level_r;
    assign push_ok_s = PushxSI & ~FullxSO;
    assign pop_ok_s  = PopxSI & ~EmptyxSO;

`ifdef KECCAK_RAND_ZEROIZE_EN
    assign DataxDO = EmptyxSO ? {WIDTH{1'b0}} : mem_r[rd_ptr_r];
`else
    assign DataxDO = mem_r[rd_ptr_r];
`endif

    // Storage and pointers; a push never targets the popped slot since full blocks pushes.
    always_ff @(posedge ClkxCI or negedge RstxRBI) begin
        if (!RstxRBI) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (pop_ok_s) begin
`ifdef KECCAK_RAND_ZEROIZE_EN
                mem_r[rd_ptr_r] <= '0;
`endif
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= DataxDI;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
        end
    end

    // Occupancy count; simultaneous push and pop leaves it unchanged.
    always_ff @(posedge ClkxCI or negedge RstxRBI) begin
        if (!RstxRBI) begin
            level_r <= '0;
        end else begin
            case ({push_ok_s, pop_ok_s})
                2'b10:   level_r <= level_r + LVL_W'(1);
                2'b01:   level_r <= level_r - LVL_W'(1);
                default: level_r <= level_r;
            endcase
        end
    end

endmodule

// File: rtl/keccak_rand_buffer.sv
// Packs PRNG words into complete fresh-mask Z vectors and buffers them for the masked S-box.
// Optional build macro: KECCAK_RAND_ZEROIZE_EN (clear consumed slots and the accumulator).
module keccak_rand_buffer
    import keccak_masked_pkg::*;
#(
    parameter int SHARES    = 5,
    parameter int LESS_RAND = 0,
    parameter int RAND_W    = 32,
    parameter int DEPTH     = 4,
    localparam int Z_W      = z_width(SHARES),
    localparam int LVL_W    = $clog2(DEPTH + 1)
) (
    input  logic              ClkxCI,
    input  logic              RstxRBI,
    input  logic [RAND_W-1:0] RandxDI,
    input  logic              RandValidxSI,
    output logic              RandReadyxSO,
    output logic [Z_W-1:0]    ZxDO,
    output logic              ZValidxSO,
    input  logic              ZReadyxSI,
    output logic [LVL_W-1:0]  LevelxDO
);

    localparam int NEED  = z_need(SHARES, LESS_RAND);
    localparam int WPZ   = words_per_z(NEED, RAND_W);
    localparam int CNT_W = (WPZ > 1) ? $clog2(WPZ) : 1;
    localparam int ACC_W = WPZ * RAND_W;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WPZ - 1);

    logic [CNT_W-1:0] cnt_r;
    logic [ACC_W-1:0] acc_r;
    logic [ACC_W-1:0] full_s;
    logic [Z_W-1:0]   z_s;
    logic             last_s;
    logic             take_s;
    logic             push_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;

    assign last_s       = (cnt_r == LAST_CNT);
    // Depends on registered state only, so no path from ZReadyxSI.
    assign RandReadyxSO = ~last_s | ~fifo_full_s;
    assign take_s       = RandValidxSI & RandReadyxSO;
    assign push_s       = take_s & last_s;
    assign ZValidxSO    = ~fifo_empty_s;

    // Assemble the vector with the incoming last word; bits at or above NEED are dropped.
    always_comb begin
        full_s = acc_r;
        full_s[ACC_W-1 -: RAND_W] = RandxDI;
        z_s = '0;
        z_s[NEED-1:0] = full_s[NEED-1:0];
    end

    // Word counter and partial-vector accumulator.
    always_ff @(posedge ClkxCI or negedge RstxRBI) begin
        if (!RstxRBI) begin
            cnt_r <= '0;
            acc_r <= '0;
        end else if (take_s) begin
            if (last_s) begin
                cnt_r <= '0;
`ifdef KECCAK_RAND_ZEROIZE_EN
                acc_r <= '0;
`endif
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
                acc_r[cnt_r * RAND_W +: RAND_W] <= RandxDI;
            end
        end
    end

    keccak_rand_fifo #(
        .WIDTH (Z_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .ClkxCI   (ClkxCI),
        .RstxRBI  (RstxRBI),
        .PushxSI  (push_s),
        .DataxDI  (z_s),
        .PopxSI   (ZReadyxSI),
        .DataxDO  (ZxDO),
        .FullxSO  (fifo_full_s),
        .EmptyxSO (fifo_empty_s),
        .LevelxDO (LevelxDO)
    );

endmodule

// File: tb/tb_keccak_rand_buffer.sv
// Self-checking bench for keccak_rand_buffer against a queue-based reference model.
module tb_keccak_rand_buffer;

    localparam int DEPTH = 4;
    localparam int WPZ   = 2;

    logic        ClkxCI = 1'b0;
    logic        RstxRBI = 1'b0;
    logic [31:0] RandxDI = 32'd0;
    logic        RandValidxSI = 1'b0;
    logic        RandReadyxSO;
    logic [49:0] ZxDO;
    logic        ZValidxSO;
    logic        ZReadyxSI = 1'b0;
    logic [2:0]  LevelxDO;

    logic [31:0] lr_data = 32'd0;
    logic        lr_valid = 1'b0;
    logic        lr_ready;
    logic [49:0] lr_z;
    logic        lr_zvalid;
    logic        lr_zready = 1'b0;
    logic [2:0]  lr_level;

    int tests_run = 0;
    int failed = 0;

    logic [49:0] q[$];
    logic [31:0] pend[$];

    always #5 ClkxCI = ~ClkxCI;

    keccak_rand_buffer #(.SHARES(5), .LESS_RAND(0), .RAND_W(32), .DEPTH(DEPTH)) dut (
        .ClkxCI(ClkxCI), .RstxRBI(RstxRBI), .RandxDI(RandxDI), .RandValidxSI(RandValidxSI),
        .RandReadyxSO(RandReadyxSO), .ZxDO(ZxDO), .ZValidxSO(ZValidxSO),
        .ZReadyxSI(ZReadyxSI), .LevelxDO(LevelxDO)
    );

    keccak_rand_buffer #(.SHARES(5), .LESS_RAND(1), .RAND_W(32), .DEPTH(DEPTH)) dut_lr (
        .ClkxCI(ClkxCI), .RstxRBI(RstxRBI), .RandxDI(lr_data), .RandValidxSI(lr_valid),
        .RandReadyxSO(lr_ready), .ZxDO(lr_z), .ZValidxSO(lr_zvalid),
        .ZReadyxSI(lr_zready), .LevelxDO(lr_level)
    );

    // Z vector from two words: word 0 at bits [31:0], word 1 above, keep the low 50 bits.
    function automatic logic [49:0] pack(input logic [31:0] w0, input logic [31:0] w1);
        logic [63:0] t;
        t = {w1, w0};
        return t[49:0];
    endfunction

    function automatic bit m_ready();
        return !(pend.size() == WPZ - 1 && q.size() == DEPTH);
    endfunction

    // One clock of stimulus; the model advances with the handshakes the spec defines.
    task automatic step(input bit v, input logic [31:0] d, input bit zr);
        bit acc;
        bit pop;
        RandValidxSI = v;
        RandxDI      = d;
        ZReadyxSI    = zr;
        acc = v && m_ready();
        pop = zr && (q.size() != 0);
        @(posedge ClkxCI);
        #1;
        if (pop) void'(q.pop_front());
        if (acc) begin
            pend.push_back(d);
            if (pend.size() == WPZ) begin
                q.push_back(pack(pend[0], pend[1]));
                pend.delete();
            end
        end
        RandValidxSI = 1'b0;
        ZReadyxSI    = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] a;
        logic [31:0] b;
        step(1'b1, $urandom, 1'b0);
        RstxRBI = 1'b0;
        #2;
        q.delete();
        pend.delete();
        tests_run++; if (ZValidxSO !== 1'b0) begin failed++; $display("FAIL reset_zvalid got %0b want 0", ZValidxSO); end
        tests_run++; if (ZxDO !== 50'd0) begin failed++; $display("FAIL reset_z got %h want 0", ZxDO); end
        tests_run++; if (LevelxDO !== 3'd0) begin failed++; $display("FAIL reset_level got %0d want 0", LevelxDO); end
        tests_run++; if (RandReadyxSO !== 1'b1) begin failed++; $display("FAIL reset_ready got %0b want 1", RandReadyxSO); end
        @(negedge ClkxCI);
        RstxRBI = 1'b1;
        a = $urandom;
        b = $urandom;
        step(1'b1, a, 1'b0);
        tests_run++; if (ZValidxSO !== 1'b0) begin failed++; $display("FAIL reset_partial_discard got %0b want 0", ZValidxSO); end
        step(1'b1, b, 1'b0);
        tests_run++; if (ZxDO !== pack(a, b) || ZValidxSO !== 1'b1) begin
            failed++; $display("FAIL reset_fresh_vector got %h/%0b want %h/1", ZxDO, ZValidxSO, pack(a, b));
        end
        step(1'b0, 32'd0, 1'b1);
    endtask

    task automatic test_pack();
        step(1'b1, 32'h89ABCDEF, 1'b0);
        tests_run++; if (ZValidxSO !== 1'b0) begin failed++; $display("FAIL pack_early_valid got %0b want 0", ZValidxSO); end
        step(1'b1, 32'hFFFC0123, 1'b0);
        tests_run++; if (ZValidxSO !== 1'b1) begin failed++; $display("FAIL pack_valid got %0b want 1", ZValidxSO); end
        tests_run++; if (ZxDO !== 50'h0012389ABCDEF) begin failed++; $display("FAIL pack_z got %h want 0012389abcdef", ZxDO); end
        tests_run++; if (LevelxDO !== 3'd1) begin failed++; $display("FAIL pack_level got %0d want 1", LevelxDO); end
        step(1'b0, 32'd0, 1'b1);
    endtask

    task automatic test_full();
        logic [31:0] w10;
        for (int i = 0; i < 9; i++) begin
            if (i == 8) begin
                tests_run++; if (RandReadyxSO !== 1'b1) begin failed++; $display("FAIL full_ninth_ready got %0b want 1", RandReadyxSO); end
            end
            step(1'b1, $urandom, 1'b0);
            if (i == 7) begin
                tests_run++; if (LevelxDO !== 3'd4) begin failed++; $display("FAIL full_level got %0d want 4", LevelxDO); end
            end
        end
        tests_run++; if (RandReadyxSO !== 1'b0) begin failed++; $display("FAIL full_tenth_ready got %0b want 0", RandReadyxSO); end
        w10 = $urandom;
        step(1'b1, w10, 1'b0);
        tests_run++; if (LevelxDO !== 3'd4 || RandReadyxSO !== 1'b0) begin
            failed++; $display("FAIL full_hold got level %0d ready %0b want 4/0", LevelxDO, RandReadyxSO);
        end
        step(1'b1, w10, 1'b1);
        tests_run++; if (LevelxDO !== 3'd3 || RandReadyxSO !== 1'b1) begin
            failed++; $display("FAIL full_after_pop got level %0d ready %0b want 3/1", LevelxDO, RandReadyxSO);
        end
        step(1'b1, w10, 1'b0);
        tests_run++; if (LevelxDO !== 3'd4) begin failed++; $display("FAIL full_tenth_push got level %0d want 4", LevelxDO); end
        for (int i = 0; i < 2 * DEPTH && q.size() != 0; i++) begin
            tests_run++; if (ZxDO !== q[0]) begin failed++; $display("FAIL full_order got %h want %h", ZxDO, q[0]); end
            step(1'b0, 32'd0, 1'b1);
        end
        tests_run++; if (ZValidxSO !== 1'b0) begin failed++; $display("FAIL full_drained got %0b want 0", ZValidxSO); end
    endtask

    task automatic test_push_pop();
        logic [31:0] w[6];
        for (int i = 0; i < 6; i++) w[i] = $urandom;
        for (int i = 0; i < 5; i++) step(1'b1, w[i], 1'b0);
        tests_run++; if (LevelxDO !== 3'd2 || ZxDO !== pack(w[0], w[1])) begin
            failed++; $display("FAIL pushpop_pre got level %0d z %h want 2 %h", LevelxDO, ZxDO, pack(w[0], w[1]));
        end
        step(1'b1, w[5], 1'b1);
        tests_run++; if (LevelxDO !== 3'd2) begin failed++; $display("FAIL pushpop_level got %0d want 2", LevelxDO); end
        tests_run++; if (ZxDO !== pack(w[2], w[3])) begin failed++; $display("FAIL pushpop_head got %h want %h", ZxDO, pack(w[2], w[3])); end
        step(1'b0, 32'd0, 1'b1);
        tests_run++; if (ZxDO !== pack(w[4], w[5])) begin failed++; $display("FAIL pushpop_newest got %h want %h", ZxDO, pack(w[4], w[5])); end
        step(1'b0, 32'd0, 1'b1);
    endtask

    task automatic test_less_rand();
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] t;
        for (int k = 0; k < 4; k++) begin
            a = (k == 0) ? 32'hFFFFFFFF : $urandom;
            b = (k == 0) ? 32'hFFFFFFFF : $urandom;
            t = {b, a} & ((64'd1 << 45) - 64'd1);
            lr_valid = 1'b1; lr_data = a;
            @(posedge ClkxCI); #1;
            lr_data = b;
            @(posedge ClkxCI); #1;
            lr_valid = 1'b0;
            tests_run++; if (lr_zvalid !== 1'b1 || lr_z !== t[49:0]) begin
                failed++; $display("FAIL less_rand_z got %h/%0b want %h/1", lr_z, lr_zvalid, t[49:0]);
            end
            lr_zready = 1'b1;
            @(posedge ClkxCI); #1;
            lr_zready = 1'b0;
            tests_run++; if (lr_level !== 3'd0) begin failed++; $display("FAIL less_rand_pop got level %0d want 0", lr_level); end
        end
    endtask

    task automatic test_zeroize();
`ifdef KECCAK_RAND_ZEROIZE_EN
        step(1'b1, $urandom, 1'b0);
        step(1'b1, $urandom, 1'b0);
        step(1'b0, 32'd0, 1'b1);
        tests_run++; if (ZxDO !== 50'd0 || ZValidxSO !== 1'b0) begin
            failed++; $display("FAIL zeroize_out got %h/%0b want 0/0", ZxDO, ZValidxSO);
        end
        for (int i = 0; i < DEPTH; i++) begin
            tests_run++; if (dut.u_fifo.mem_r[i] !== 50'd0) begin failed++; $display("FAIL zeroize_slot%0d got %h want 0", i, dut.u_fifo.mem_r[i]); end
        end
        tests_run++; if (dut.acc_r !== 64'd0) begin failed++; $display("FAIL zeroize_acc got %h want 0", dut.acc_r); end
`endif
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 1) == 1);
            tests_run++; if (LevelxDO !== 3'(q.size()) || ZValidxSO !== (q.size() != 0) || RandReadyxSO !== m_ready()) begin
                failed++; $display("FAIL random_ctrl cyc %0d got lvl %0d v %0b rdy %0b want %0d %0b %0b",
                                   i, LevelxDO, ZValidxSO, RandReadyxSO, q.size(), q.size() != 0, m_ready());
            end
            if (q.size() != 0) begin
                tests_run++; if (ZxDO !== q[0]) begin failed++; $display("FAIL random_data cyc %0d got %h want %h", i, ZxDO, q[0]); end
            end
        end
        for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 32'd0, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(negedge ClkxCI);
        RstxRBI = 1'b1;
        @(posedge ClkxCI); #1;
        test_reset();
        test_pack();
        test_full();
        test_push_pop();
        test_less_rand();
        test_zeroize();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
